// File: rtl/dbus_gpio_pkg.sv
// Shared data-bus payload types, GPIO register map and helpers for the GPIO responder.
//   type_dbus2peri_s : request from the interconnect (addr, w_data, sel_byte, req, w_en)
//   type_peri2dbus_s : response to the interconnect (r_data, ack)
//   type_gpio_fsm_e  : responder FSM states
package dbus_gpio_pkg;

    localparam int unsigned DBUS_ADDR_W = 32;
    localparam int unsigned DBUS_DATA_W = 32;
    localparam int unsigned DBUS_SEL_W  = DBUS_DATA_W / 8;

    typedef struct packed {
        logic [DBUS_ADDR_W-1:0] addr;
        logic [DBUS_DATA_W-1:0] w_data;
        logic [DBUS_SEL_W-1:0]  sel_byte;
        logic                   req;
        logic                   w_en;
    } type_dbus2peri_s;

    typedef struct packed {
        logic [DBUS_DATA_W-1:0] r_data;
        logic                   ack;
    } type_peri2dbus_s;

    typedef enum logic [1:0] {
        GPIO_IDLE = 2'd0,
        GPIO_WAIT = 2'd1,
        GPIO_RESP = 2'd2
    } type_gpio_fsm_e;

    // Byte offsets of the GPIO registers.
    localparam logic [7:0] GPIO_OFS_DATA_OUT   = 8'h00;
    localparam logic [7:0] GPIO_OFS_DATA_IN    = 8'h04;
    localparam logic [7:0] GPIO_OFS_OE         = 8'h08;
    localparam logic [7:0] GPIO_OFS_IRQ_EN     = 8'h0C;
    localparam logic [7:0] GPIO_OFS_IRQ_STATUS = 8'h10;

    // Word indices as seen on addr[4:2].
    localparam logic [2:0] GPIO_IDX_DATA_OUT   = GPIO_OFS_DATA_OUT[4:2];
    localparam logic [2:0] GPIO_IDX_DATA_IN    = GPIO_OFS_DATA_IN[4:2];
    localparam logic [2:0] GPIO_IDX_OE         = GPIO_OFS_OE[4:2];
    localparam logic [2:0] GPIO_IDX_IRQ_EN     = GPIO_OFS_IRQ_EN[4:2];
    localparam logic [2:0] GPIO_IDX_IRQ_STATUS = GPIO_OFS_IRQ_STATUS[4:2];

    // Address window decoded by the interconnect: a 32-byte block.
    localparam logic [DBUS_ADDR_W-1:0] GPIO_ADDR_BASE = 32'h1000_4000;
    localparam logic [DBUS_ADDR_W-1:0] GPIO_ADDR_MASK = 32'hFFFF_FFE0;

    function automatic logic GPIO_ADDR_MATCH(input logic [DBUS_ADDR_W-1:0] addr);
        return (addr & GPIO_ADDR_MASK) == GPIO_ADDR_BASE;
    endfunction

    // Expand byte-lane selects into a bit mask.
    function automatic logic [DBUS_DATA_W-1:0] lane_mask(input logic [DBUS_SEL_W-1:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

    // Replace the masked bits of a register with write data.
    function automatic logic [DBUS_DATA_W-1:0] merge_bits(input logic [DBUS_DATA_W-1:0] old_val,
                                                          input logic [DBUS_DATA_W-1:0] new_val,
                                                          input logic [DBUS_DATA_W-1:0] mask);
        return (old_val & ~mask) | (new_val & mask);
    endfunction

endpackage

// File: rtl/gpio_in_sync.sv
// Pin input conditioning: two-flop synchronizer, previous-value flop and rising-edge detect.
//   clk, rst : clock, synchronous active-high reset
//   pin      : asynchronous pin inputs
//   sync     : synchronized pin values
//   rise_c   : combinational rising-edge flags (sync & ~prev)
module gpio_in_sync #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pin,
    output logic [WIDTH-1:0] sync,
    output logic [WIDTH-1:0] rise_c
);

    logic [WIDTH-1:0] meta;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] prev;

    // Synchronizer chain plus one history stage for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta   <= '0;
            sync_q <= '0;
            prev   <= '0;
        end else begin
            meta   <= pin;
            sync_q <= meta;
            prev   <= sync_q;
        end
    end

    assign sync   = sync_q;
    assign rise_c = sync_q & ~prev;

endmodule

// File: rtl/dbus_gpio.sv
// Memory-mapped GPIO responder on the data bus.
//   clk, rst     : clock, synchronous active-high reset
//   dbus2peri_i  : request from the interconnect
//   gpio_sel_i   : device select from the address decoder
//   gpio2dbus_o  : registered response (r_data, one-cycle ack)
//   gpio_in_i    : asynchronous pin inputs
//   gpio_out_o   : pin output values (DATA_OUT)
//   gpio_oe_o    : pin output enables (OE), 1 = drive
//   gpio_irq_o   : registered level interrupt, |(IRQ_STATUS & IRQ_EN)
module dbus_gpio
    import dbus_gpio_pkg::*;
#(
    parameter int unsigned GPIO_WIDTH  = 32,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  type_dbus2peri_s       dbus2peri_i,
    input  logic                  gpio_sel_i,
    output type_peri2dbus_s       gpio2dbus_o,
    input  logic [GPIO_WIDTH-1:0] gpio_in_i,
    output logic [GPIO_WIDTH-1:0] gpio_out_o,
    output logic [GPIO_WIDTH-1:0] gpio_oe_o,
    output logic                  gpio_irq_o
);

    localparam int unsigned CNT_W = 4;
    // Register bits that exist; everything above GPIO_WIDTH stays 0.
    localparam logic [DBUS_DATA_W-1:0] WIDTH_MASK = DBUS_DATA_W'((64'd1 << GPIO_WIDTH) - 64'd1);

    type_gpio_fsm_e         state;
    type_gpio_fsm_e         state_next;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_next;
    logic                   start;

    logic [2:0]             req_idx;
    logic                   req_wen;
    logic [DBUS_DATA_W-1:0] req_wdata;
    logic [DBUS_SEL_W-1:0]  req_sel;

    logic [DBUS_DATA_W-1:0] data_out;
    logic [DBUS_DATA_W-1:0] oe;
    logic [DBUS_DATA_W-1:0] irq_en;
    logic [DBUS_DATA_W-1:0] irq_status;
    logic [DBUS_DATA_W-1:0] irq_status_next;
    logic                   irq;

    logic [GPIO_WIDTH-1:0]  in_sync;
    logic [GPIO_WIDTH-1:0]  in_rise_c;
    logic [DBUS_DATA_W-1:0] data_in;
    logic [DBUS_DATA_W-1:0] rise;

    logic [2:0]             rd_idx;
    logic                   rd_wen;
    logic [DBUS_DATA_W-1:0] rd_value;
    logic [DBUS_DATA_W-1:0] resp_data_next;
    logic [DBUS_DATA_W-1:0] resp_data;
    logic                   ack;

    logic                   commit;
    logic [DBUS_DATA_W-1:0] wr_mask;
    logic [DBUS_DATA_W-1:0] w1c_mask;

    // Only addr[4:2] selects a register; the remaining address bits are don't-care.
    logic unused_addr;
    assign unused_addr = ^{dbus2peri_i.addr[DBUS_ADDR_W-1:5], dbus2peri_i.addr[1:0]};

    gpio_in_sync #(
        .WIDTH (GPIO_WIDTH)
    ) u_in_sync (
        .clk    (clk),
        .rst    (rst),
        .pin    (gpio_in_i),
        .sync   (in_sync),
        .rise_c (in_rise_c)
    );

    assign data_in = DBUS_DATA_W'(in_sync);
    assign rise    = DBUS_DATA_W'(in_rise_c);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= GPIO_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // FSM next state: capture in IDLE, count down wait states, ack for one cycle.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        start      = 1'b0;
        case (state)
            GPIO_IDLE: begin
                if (gpio_sel_i && dbus2peri_i.req) begin
                    start = 1'b1;
                    if (WAIT_STATES == 0) begin
                        state_next = GPIO_RESP;
                    end else begin
                        state_next = GPIO_WAIT;
                        cnt_next   = CNT_W'(WAIT_STATES - 1);
                    end
                end
            end
            GPIO_WAIT: begin
                if (cnt == '0) begin
                    state_next = GPIO_RESP;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            GPIO_RESP: begin
                state_next = GPIO_IDLE;
            end
            default: begin
                state_next = GPIO_IDLE;
            end
        endcase
    end

    // Read data is sampled on the edge that enters RESP; with no wait states that is the
    // capture edge itself, so the live bus fields are used while still in IDLE.
    always_comb begin
        rd_idx = (state == GPIO_IDLE) ? dbus2peri_i.addr[4:2] : req_idx;
        rd_wen = (state == GPIO_IDLE) ? dbus2peri_i.w_en : req_wen;
        case (rd_idx)
            GPIO_IDX_DATA_OUT:   rd_value = data_out;
            GPIO_IDX_DATA_IN:    rd_value = data_in;
            GPIO_IDX_OE:         rd_value = oe;
            GPIO_IDX_IRQ_EN:     rd_value = irq_en;
            GPIO_IDX_IRQ_STATUS: rd_value = irq_status;
            default:             rd_value = '0;
        endcase
        resp_data_next = ((state_next == GPIO_RESP) && !rd_wen) ? rd_value : '0;
    end

    // Write commit and W1C; a same-cycle rise wins over the clear.
    always_comb begin
        commit          = (state == GPIO_RESP) && req_wen;
        wr_mask         = lane_mask(req_sel) & WIDTH_MASK;
        w1c_mask        = (commit && (req_idx == GPIO_IDX_IRQ_STATUS)) ? (req_wdata & wr_mask) : '0;
        irq_status_next = ((irq_status & ~w1c_mask) | rise) & WIDTH_MASK;
    end

    // Request capture, response, register file and interrupt.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_idx    <= '0;
            req_wen    <= 1'b0;
            req_wdata  <= '0;
            req_sel    <= '0;
            ack        <= 1'b0;
            resp_data  <= '0;
            data_out   <= '0;
            oe         <= '0;
            irq_en     <= '0;
            irq_status <= '0;
            irq        <= 1'b0;
        end else begin
            if (start) begin
                req_idx   <= dbus2peri_i.addr[4:2];
                req_wen   <= dbus2peri_i.w_en;
                req_wdata <= dbus2peri_i.w_data;
                req_sel   <= dbus2peri_i.sel_byte;
            end
            ack        <= (state_next == GPIO_RESP);
            resp_data  <= resp_data_next;
            irq_status <= irq_status_next;
            irq        <= |(irq_status & irq_en);
            if (commit) begin
                case (req_idx)
                    GPIO_IDX_DATA_OUT: data_out <= merge_bits(data_out, req_wdata, wr_mask);
                    GPIO_IDX_OE:       oe       <= merge_bits(oe, req_wdata, wr_mask);
                    GPIO_IDX_IRQ_EN:   irq_en   <= merge_bits(irq_en, req_wdata, wr_mask);
                    default: ;
                endcase
            end
        end
    end

    assign gpio2dbus_o.r_data = resp_data;
    assign gpio2dbus_o.ack    = ack;
    assign gpio_out_o         = data_out[GPIO_WIDTH-1:0];
    assign gpio_oe_o          = oe[GPIO_WIDTH-1:0];
    assign gpio_irq_o         = irq;

endmodule

// File: tb/tb_dbus_gpio.sv
// Bench for dbus_gpio: three instances (WAIT_STATES 0/3/5, one with GPIO_WIDTH 12),
// vector table plus hand sequences, response scoreboard on every ack.
module tb_dbus_gpio;
    import dbus_gpio_pkg::*;

    localparam int NDUT = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst  [NDUT];
    type_dbus2peri_s bus  [NDUT];
    logic            sel  [NDUT];
    type_peri2dbus_s resp [NDUT];
    logic [31:0]     gin  [NDUT];
    logic [31:0]     gout [NDUT];
    logic [31:0]     goe  [NDUT];
    logic            irq  [NDUT];

    int total = 0;
    int bad   = 0;
    bit mon_en = 1'b0;

    typedef struct {
        int          inst;
        logic [31:0] rd;
    } sb_t;
    sb_t sb_q [$];

    typedef struct {
        int          inst;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wd;
        logic [3:0]  sb;
        logic [31:0] rd;
    } vec_t;
    vec_t vecs [$];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int unsigned WS = (g == 0) ? 0 : ((g == 1) ? 3 : 5);
        localparam int unsigned GW = (g == 1) ? 12 : 32;
        logic [GW-1:0] out_w;
        logic [GW-1:0] oe_w;
        dbus_gpio #(
            .GPIO_WIDTH  (GW),
            .WAIT_STATES (WS)
        ) u_dut (
            .clk         (clk),
            .rst         (rst[g]),
            .dbus2peri_i (bus[g]),
            .gpio_sel_i  (sel[g]),
            .gpio2dbus_o (resp[g]),
            .gpio_in_i   (gin[g][GW-1:0]),
            .gpio_out_o  (out_w),
            .gpio_oe_o   (oe_w),
            .gpio_irq_o  (irq[g])
        );
        assign gout[g] = 32'(out_w);
        assign goe[g]  = 32'(oe_w);
    end

    function automatic int ws_of(input int i);
        case (i)
            0:       return 0;
            1:       return 3;
            default: return 5;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void add(input int i, input logic [31:0] a, input logic we,
                                input logic [31:0] wd, input logic [3:0] sb, input logic [31:0] rd);
        vec_t v;
        v.inst = i; v.addr = a; v.we = we; v.wd = wd; v.sb = sb; v.rd = rd;
        vecs.push_back(v);
    endfunction

    // Scoreboard: every ack pops one expected response; r_data must be 0 without ack.
    always @(negedge clk) begin : mon
        sb_t e;
        if (mon_en) begin
            for (int i = 0; i < NDUT; i++) begin
                if (resp[i].ack === 1'b1) begin
                    if (sb_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL sb_unexpected_ack: dut %0d acked with nothing outstanding", i);
                    end else begin
                        e = sb_q.pop_front();
                        chk($sformatf("sb_dut_dut%0d", i), 32'(i), 32'(e.inst));
                        chk($sformatf("sb_rdata_dut%0d", i), resp[i].r_data, e.rd);
                    end
                end else begin
                    chk($sformatf("idle_rdata_dut%0d", i), resp[i].r_data, 32'h0);
                end
            end
        end
    end

    // One bus transaction; called and returns at posedge+1.
    task automatic xact(input int i, input logic [31:0] addr, input logic we,
                        input logic [31:0] wd, input logic [3:0] sb, input logic [31:0] rd);
        sb_t e;
        int  lat;
        bit  got;
        e.inst = i;
        e.rd   = we ? 32'h0 : rd;
        sb_q.push_back(e);
        bus[i].addr     = addr;
        bus[i].w_data   = wd;
        bus[i].sel_byte = sb;
        bus[i].w_en     = we;
        bus[i].req      = 1'b1;
        sel[i]          = 1'b1;
        @(posedge clk);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            if (resp[i].ack === 1'b1) got = 1'b1;
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL ack_timeout: dut %0d addr %h got no ack, required after %0d cycles", i, addr, 1 + ws_of(i));
            if (sb_q.size() > 0) void'(sb_q.pop_back());
        end else begin
            chk($sformatf("latency_dut%0d_addr%h", i, addr), 32'(lat), 32'(1 + ws_of(i)));
        end
        @(posedge clk);
        #1;
        bus[i] = '0;
        sel[i] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks;
        for (int i = 0; i < NDUT; i++) begin
            rst[i] = 1'b1;
            bus[i] = '0;
            sel[i] = 1'b0;
            gin[i] = 32'h0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NDUT; i++) rst[i] = 1'b0;

        // Reset state.
        @(negedge clk);
        for (int i = 0; i < NDUT; i++) begin
            chk($sformatf("rst_ack_dut%0d", i), 32'(resp[i].ack), 32'h0);
            chk($sformatf("rst_rdata_dut%0d", i), resp[i].r_data, 32'h0);
            chk($sformatf("rst_out_dut%0d", i), gout[i], 32'h0);
            chk($sformatf("rst_oe_dut%0d", i), goe[i], 32'h0);
            chk($sformatf("rst_irq_dut%0d", i), 32'(irq[i]), 32'h0);
        end
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // Full-word write: ack one cycle after capture, pins follow the commit edge.
        begin
            sb_t e;
            e.inst = 0;
            e.rd   = 32'h0;
            sb_q.push_back(e);
        end
        bus[0].addr = 32'h0; bus[0].w_data = 32'hA5A5_5A5A; bus[0].sel_byte = 4'hF;
        bus[0].w_en = 1'b1;  bus[0].req = 1'b1; sel[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("wr_ack_ws0", 32'(resp[0].ack), 32'h1);
        chk("out_before_commit", gout[0], 32'h0);
        @(posedge clk);
        #1;
        bus[0] = '0;
        sel[0] = 1'b0;
        chk("out_after_commit", gout[0], 32'hA5A5_5A5A);

        // Vector table.
        add(0, 32'h00, 1'b0, 32'h0,         4'h0, 32'hA5A5_5A5A);
        add(0, 32'h08, 1'b1, 32'h3C3C_3C3C, 4'h4, 32'h0);
        add(0, 32'h08, 1'b0, 32'h0,         4'h0, 32'h003C_0000);
        add(0, 32'h14, 1'b0, 32'h0,         4'h0, 32'h0);
        add(0, 32'h14, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'h0);
        add(0, 32'h1C, 1'b0, 32'h0,         4'h0, 32'h0);
        add(0, 32'h23, 1'b0, 32'h0,         4'h0, 32'hA5A5_5A5A);
        add(0, 32'h00, 1'b1, 32'h1122_3344, 4'h3, 32'h0);
        add(0, 32'h00, 1'b0, 32'h0,         4'h0, 32'hA5A5_3344);
        add(0, 32'h0C, 1'b1, 32'h0000_0001, 4'hF, 32'h0);
        add(0, 32'h0C, 1'b0, 32'h0,         4'h0, 32'h0000_0001);
        add(0, 32'h04, 1'b0, 32'h0,         4'h0, 32'h0);
        add(1, 32'h00, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'h0);
        add(1, 32'h00, 1'b0, 32'h0,         4'h0, 32'h0000_0FFF);
        add(1, 32'h08, 1'b1, 32'hFFFF_FFFF, 4'h8, 32'h0);
        add(1, 32'h08, 1'b0, 32'h0,         4'h0, 32'h0);
        add(1, 32'h04, 1'b0, 32'h0,         4'h0, 32'h0);
        add(1, 32'h10, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'h0);
        add(1, 32'h10, 1'b0, 32'h0,         4'h0, 32'h0);
        add(2, 32'h0C, 1'b1, 32'h00FF_00FF, 4'h5, 32'h0);
        add(2, 32'h0C, 1'b0, 32'h0,         4'h0, 32'h00FF_00FF);
        for (int k = 0; k < vecs.size(); k++) begin
            xact(vecs[k].inst, vecs[k].addr, vecs[k].we, vecs[k].wd, vecs[k].sb, vecs[k].rd);
        end
        chk("pins_out_dut0", gout[0], 32'hA5A5_3344);
        chk("pins_oe_dut0", goe[0], 32'h003C_0000);
        chk("pins_out_dut1", gout[1], 32'h0000_0FFF);
        chk("pins_oe_dut1", goe[1], 32'h0);

        // Rising edge on pin 0: status after three edges, irq one edge later, W1C clears.
        chk("irq_idle", 32'(irq[0]), 32'h0);
        gin[0][0] = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("irq_lags_status", 32'(irq[0]), 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk("irq_set", 32'(irq[0]), 32'h1);
        @(posedge clk);
        #1;
        xact(0, 32'h10, 1'b0, 32'h0, 4'h0, 32'h1);
        xact(0, 32'h04, 1'b0, 32'h0, 4'h0, 32'h1);
        xact(0, 32'h10, 1'b1, 32'h1, 4'h1, 32'h0);
        @(negedge clk);
        chk("irq_lags_clear", 32'(irq[0]), 32'h1);
        @(posedge clk);
        @(negedge clk);
        chk("irq_cleared", 32'(irq[0]), 32'h0);
        @(posedge clk);
        #1;
        xact(0, 32'h10, 1'b0, 32'h0, 4'h0, 32'h0);

        // Rise lands in the same cycle as a W1C commit of the same bit.
        gin[0][0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        gin[0][0] = 1'b1;
        @(posedge clk);
        #1;
        xact(0, 32'h10, 1'b1, 32'h1, 4'h1, 32'h0);
        xact(0, 32'h10, 1'b0, 32'h0, 4'h0, 32'h1);

        // Reset during WAIT of a write: no ack, write dropped, next request normal.
        bus[2].addr = 32'h0; bus[2].w_data = 32'hFFFF_FFFF; bus[2].sel_byte = 4'hF;
        bus[2].w_en = 1'b1;  bus[2].req = 1'b1; sel[2] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst[2] = 1'b1;
        @(posedge clk);
        #1;
        rst[2] = 1'b0;
        bus[2] = '0;
        sel[2] = 1'b0;
        acks = 0;
        repeat (10) begin
            @(negedge clk);
            if (resp[2].ack === 1'b1) acks++;
        end
        chk("rst_wait_no_ack", 32'(acks), 32'h0);
        chk("rst_wait_out", gout[2], 32'h0);
        @(posedge clk);
        #1;
        xact(2, 32'h00, 1'b0, 32'h0, 4'h0, 32'h0);
        xact(2, 32'h0C, 1'b0, 32'h0, 4'h0, 32'h0);
        chk("sb_drained", 32'(sb_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
